lane_traffic_sensor: RTL and testbench

- Upstream stage of Breadboard: turns raw per-lane vehicle-arrival pulses and emergency-vehicle requests into the packed lane-count bus, emgSignal and emgLane that Breadboard consumes.
- Closes the loop on Breadboard's trafficLightOutput: cars drain from a lane only while its light is green.
- Also arbitrates concurrent emergency requests into a single one-hot emgLane, held until that lane clears.

---
 rtl/traffic_pkg.sv | 56 +++++
 rtl/lane_counter.sv | 103 ++++++++++
 rtl/lane_traffic_sensor.sv | 148 ++++++++++++++
 tb/tb_lane_traffic_sensor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the lane traffic sensor: lane sizing, slot
//   indices, the emergency FSM state type and small helpers mapping
//   Breadboard light bits to lane slots and picking the winning request.
package traffic_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 8;

  localparam logic [2:0] SLOT_N2 = 3'd0;
  localparam logic [2:0] SLOT_N1 = 3'd1;
  localparam logic [2:0] SLOT_E2 = 3'd2;
  localparam logic [2:0] SLOT_E1 = 3'd3;
  localparam logic [2:0] SLOT_S2 = 3'd4;
  localparam logic [2:0] SLOT_S1 = 3'd5;
  localparam logic [2:0] SLOT_W2 = 3'd6;
  localparam logic [2:0] SLOT_W1 = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } emg_state_t;

  // Breadboard orders its light outputs differently from the lane bus.
  function automatic logic [2:0] light_to_slot(input logic [2:0] light_bit);
    logic [2:0] slot;
    case (light_bit)
      3'd0:    slot = SLOT_S1;
      3'd1:    slot = SLOT_S2;
      3'd2:    slot = SLOT_E1;
      3'd3:    slot = SLOT_E2;
      3'd4:    slot = SLOT_N1;
      3'd5:    slot = SLOT_N2;
      3'd6:    slot = SLOT_W1;
      3'd7:    slot = SLOT_W2;
      default: slot = SLOT_N2;
    endcase
    return slot;
  endfunction

  // Highest-numbered asserted request wins arbitration.
  function automatic logic [2:0] highest_slot(input logic [NUM_LANES-1:0] req);
    logic [2:0] slot;
    slot = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (req[i]) begin
        slot = 3'(i);
      end else begin
        slot = slot;
      end
    end
    return slot;
  endfunction

endpackage

// File: rtl/lane_counter.sv
// lane_counter
//   One lane slot: departure timer, saturating vehicle count, sticky
//   overflow flag and a one-cycle departure pulse.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   green         this slot's light is green
//   arrive        one-cycle car arrival pulse
//   clr_ovf       synchronous clear of the overflow flag
//   count         registered vehicle count
//   ovf           sticky saturation flag
//   depart_pulse  one-cycle pulse, aligned with the decremented count
module lane_counter
  import traffic_pkg::*;
#(
  parameter int DEPART_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              green,
  input  logic              arrive,
  input  logic              clr_ovf,
  output logic [LANE_W-1:0] count,
  output logic              ovf,
  output logic              depart_pulse
);

  localparam int TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

  logic [TMR_W-1:0]  timer_r;
  logic [TMR_W-1:0]  timer_next_s;
  logic [LANE_W-1:0] count_r;
  logic [LANE_W-1:0] count_next_s;
  logic              ovf_r;
  logic              ovf_next_s;
  logic              depart_r;
  logic              draining_s;
  logic              depart_s;
  logic              sat_s;

  // Timer, depart decision, saturating count and sticky overflow.
  always_comb begin
    draining_s   = green && (count_r != '0);
    depart_s     = 1'b0;
    timer_next_s = '0;
    sat_s        = 1'b0;
    count_next_s = count_r;
    ovf_next_s   = ovf_r;

    if (draining_s) begin
      if (timer_r == TMR_W'(DEPART_CYCLES - 1)) begin
        depart_s     = 1'b1;
        timer_next_s = '0;
      end else begin
        timer_next_s = timer_r + TMR_W'(1);
      end
    end else begin
      timer_next_s = '0;
    end

    // Arrival and departure together cancel out.
    if (arrive && !depart_s) begin
      if (count_r == '1) begin
        sat_s        = 1'b1;
        count_next_s = count_r;
      end else begin
        count_next_s = count_r + LANE_W'(1);
      end
    end else if (!arrive && depart_s) begin
      count_next_s = count_r - LANE_W'(1);
    end else begin
      count_next_s = count_r;
    end

    // A new saturation outranks a simultaneous clear.
    if (sat_s) begin
      ovf_next_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r  <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
      depart_r <= 1'b0;
    end else begin
      timer_r  <= timer_next_s;
      count_r  <= count_next_s;
      ovf_r    <= ovf_next_s;
      depart_r <= depart_s;
    end
  end

  assign count        = count_r;
  assign ovf          = ovf_r;
  assign depart_pulse = depart_r;

endmodule

// File: rtl/lane_traffic_sensor.sv
// lane_traffic_sensor
//   Turns per-slot arrival pulses and emergency requests into the packed
//   lane-count bus, emgSignal and emgLane consumed by Breadboard. Cars
//   drain only while Breadboard shows green for their slot.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   arrive[8]           car arrival pulse per slot
//   emgReq[8]           emergency request level per slot
//   trafficLightOutput  Breadboard lights (1 = green), Breadboard bit order
//   clrOvf              clear all overflow flags
//   lanes[64]           counts, slot k at lanes[8k+7:8k]
//   emgSignal           emergency active
//   emgLane[8]          one-hot active emergency slot, 0 when idle
//   ovf[8]              sticky saturation flags
//   departPulse[8]      one-cycle pulse when a car leaves a slot
module lane_traffic_sensor
  import traffic_pkg::*;
#(
  parameter int DEPART_CYCLES = 4,
  parameter int EMG_TIMEOUT   = 64,
  parameter int EMG_GAP       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        arrive,
  input  logic [NUM_LANES-1:0]        emgReq,
  input  logic [NUM_LANES-1:0]        trafficLightOutput,
  input  logic                        clrOvf,
  output logic [NUM_LANES*LANE_W-1:0] lanes,
  output logic                        emgSignal,
  output logic [NUM_LANES-1:0]        emgLane,
  output logic [NUM_LANES-1:0]        ovf,
  output logic [NUM_LANES-1:0]        departPulse
);

  localparam int TMR_W = (EMG_TIMEOUT > 1) ? $clog2(EMG_TIMEOUT) : 1;
  localparam int GAP_W = (EMG_GAP > 2) ? $clog2(EMG_GAP - 1) : 1;

  logic [NUM_LANES-1:0] green_s;
  logic [LANE_W-1:0]    count_s [NUM_LANES];

  emg_state_t           state_r, state_next_s;
  logic [2:0]           slot_r, slot_next_s;
  logic [TMR_W-1:0]     tmr_r, tmr_next_s;
  logic [GAP_W-1:0]     gap_r, gap_next_s;
  logic                 emg_signal_r, emg_signal_next_s;
  logic [NUM_LANES-1:0] emg_lane_r, emg_lane_next_s;
  logic [LANE_W-1:0]    latched_count_s;
  logic [2:0]           winner_s;

  // Reorder Breadboard light bits into slot order.
  always_comb begin
    green_s = '0;
    for (int b = 0; b < NUM_LANES; b++) begin
      green_s[light_to_slot(3'(b))] = trafficLightOutput[b];
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_counter #(
      .DEPART_CYCLES(DEPART_CYCLES)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .green       (green_s[k]),
      .arrive      (arrive[k]),
      .clr_ovf     (clrOvf),
      .count       (count_s[k]),
      .ovf         (ovf[k]),
      .depart_pulse(departPulse[k])
    );
    assign lanes[LANE_W*k +: LANE_W] = count_s[k];
  end

  assign latched_count_s = count_s[slot_r];
  assign winner_s        = highest_slot(emgReq);

  // Emergency FSM next state and next registered outputs.
  // The IDLE arbitration cycle is itself the last low cycle, so GAP spans
  // EMG_GAP-1 cycles to keep emgSignal low for exactly EMG_GAP cycles
  // between back-to-back emergencies (EMG_GAP must be at least 1).
  always_comb begin
    state_next_s      = state_r;
    slot_next_s       = slot_r;
    tmr_next_s        = tmr_r;
    gap_next_s        = gap_r;
    emg_signal_next_s = emg_signal_r;
    emg_lane_next_s   = emg_lane_r;
    case (state_r)
      IDLE: begin
        if (emgReq != 8'h00) begin
          state_next_s      = ACTIVE;
          slot_next_s       = winner_s;
          tmr_next_s        = '0;
          emg_signal_next_s = 1'b1;
          emg_lane_next_s   = 8'h01 << winner_s;
        end else begin
          state_next_s      = IDLE;
        end
      end
      ACTIVE: begin
        if ((latched_count_s == '0) || (tmr_r == TMR_W'(EMG_TIMEOUT - 1))) begin
          emg_signal_next_s = 1'b0;
          emg_lane_next_s   = 8'h00;
          gap_next_s        = '0;
          state_next_s      = (EMG_GAP > 1) ? GAP : IDLE;
        end else begin
          tmr_next_s        = tmr_r + TMR_W'(1);
        end
      end
      GAP: begin
        if (gap_r == GAP_W'(EMG_GAP - 2)) begin
          state_next_s = IDLE;
        end else begin
          gap_next_s   = gap_r + GAP_W'(1);
        end
      end
      default: begin
        state_next_s      = IDLE;
        emg_signal_next_s = 1'b0;
        emg_lane_next_s   = 8'h00;
      end
    endcase
  end

  // Emergency FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      slot_r       <= 3'd0;
      tmr_r        <= '0;
      gap_r        <= '0;
      emg_signal_r <= 1'b0;
      emg_lane_r   <= 8'h00;
    end else begin
      state_r      <= state_next_s;
      slot_r       <= slot_next_s;
      tmr_r        <= tmr_next_s;
      gap_r        <= gap_next_s;
      emg_signal_r <= emg_signal_next_s;
      emg_lane_r   <= emg_lane_next_s;
    end
  end

  assign emgSignal = emg_signal_r;
  assign emgLane   = emg_lane_r;

endmodule

// File: tb/tb_lane_traffic_sensor.sv
// Scoreboard bench for lane_traffic_sensor: stimulus pushes the expected
// outputs of a lane/emergency reference model; a monitor pops and compares.
module tb_lane_traffic_sensor;

  localparam int DEP  = 4;
  localparam int TOUT = 64;
  localparam int GAPC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  arrive = 8'h00;
  logic [7:0]  emgReq = 8'h00;
  logic [7:0]  tlo = 8'h00;
  logic        clrOvf = 1'b0;
  logic [63:0] lanes;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [7:0]  ovf;
  logic [7:0]  departPulse;

  lane_traffic_sensor dut (
    .clk               (clk),
    .rst               (rst),
    .arrive            (arrive),
    .emgReq            (emgReq),
    .trafficLightOutput(tlo),
    .clrOvf            (clrOvf),
    .lanes             (lanes),
    .emgSignal         (emgSignal),
    .emgLane           (emgLane),
    .ovf               (ovf),
    .departPulse       (departPulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] lanes;
    logic [7:0]  ovf;
    logic [7:0]  dp;
    logic        sig;
    logic [7:0]  lane;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // reference model state (describes what is currently visible)
  int         cnt[8];
  int         run[8];
  logic [7:0] m_ovf;
  logic [7:0] m_dp;
  bit         m_act;
  int         m_slot;
  int         m_act_cnt;
  int         m_low;
  int         light_slot[8] = '{5, 4, 3, 2, 1, 0, 7, 6};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      cnt[k] = 0;
      run[k] = 0;
    end
    m_ovf = 8'h00;
    m_dp = 8'h00;
    m_act = 1'b0;
    m_slot = 0;
    m_act_cnt = 0;
    m_low = GAPC;
  endtask

  task automatic model_step(input logic [7:0] a, input logic [7:0] r,
                            input logic [7:0] l, input logic c);
    logic [7:0] grn;
    int hs;
    grn = 8'h00;
    hs = 0;
    for (int b = 0; b < 8; b++) if (l[b]) grn[light_slot[b]] = 1'b1;
    // emergency: uses counts visible this cycle
    if (m_act) begin
      if (cnt[m_slot] == 0 || m_act_cnt == TOUT) begin
        m_act = 1'b0;
        m_low = 1;
      end else begin
        m_act_cnt++;
      end
    end else if (m_low >= GAPC && r != 8'h00) begin
      for (int k = 0; k < 8; k++) if (r[k]) hs = k;
      m_act = 1'b1;
      m_slot = hs;
      m_act_cnt = 1;
    end else if (m_low < GAPC) begin
      m_low++;
    end
    // lanes: a car leaves after DEP consecutive green cycles with cars queued
    for (int k = 0; k < 8; k++) begin
      int dep;
      bit sat;
      dep = 0;
      if (grn[k] && cnt[k] > 0) begin
        run[k]++;
        if (run[k] == DEP) begin
          dep = 1;
          run[k] = 0;
        end
      end else begin
        run[k] = 0;
      end
      m_dp[k] = (dep == 1);
      sat = a[k] && dep == 0 && cnt[k] == 255;
      if (!sat) cnt[k] = cnt[k] + int'(a[k]) - dep;
      if (sat) m_ovf[k] = 1'b1;
      else if (c) m_ovf[k] = 1'b0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int k = 0; k < 8; k++) e.lanes[8*k +: 8] = 8'(cnt[k]);
    e.ovf = m_ovf;
    e.dp = m_dp;
    e.sig = m_act;
    e.lane = m_act ? 8'(1 << m_slot) : 8'h00;
    return e;
  endfunction

  task automatic step(input logic [7:0] a, input logic [7:0] r,
                      input logic [7:0] l, input logic c);
    @(negedge clk);
    arrive = a;
    emgReq = r;
    tlo = l;
    clrOvf = c;
    model_step(a, r, l, c);
    exp_q.push_back(model_out());
  endtask

  task automatic preload(input int slot, input int n);
    for (int i = 0; i < n; i++) step(8'(1 << slot), 8'h00, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_lanes"}, lanes, 64'h0);
    chk({tag, "_emgSignal"}, 64'(emgSignal), 64'h0);
    chk({tag, "_emgLane"}, 64'(emgLane), 64'h0);
    chk({tag, "_ovf"}, 64'(ovf), 64'h0);
    chk({tag, "_departPulse"}, 64'(departPulse), 64'h0);
  endtask

  // monitor: compares each expected snapshot after the edge it belongs to
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("lanes", lanes, mon_e.lanes);
      chk("ovf", 64'(ovf), 64'(mon_e.ovf));
      chk("departPulse", 64'(departPulse), 64'(mon_e.dp));
      chk("emgSignal", 64'(emgSignal), 64'(mon_e.sig));
      chk("emgLane", 64'(emgLane), 64'(mon_e.lane));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rl, rr;
    model_reset();
    #12;
    check_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // drain w2 (slot 6) through light bit 7
    preload(6, 3);
    for (int i = 0; i < 16; i++) step(8'h00, 8'h00, 8'h80, 1'b0);
    // green interrupted at cycle 6 restarts the timer
    preload(6, 3);
    for (int i = 0; i < 19; i++) step(8'h00, 8'h00, (i == 6) ? 8'h00 : 8'h80, 1'b0);

    // saturation on n2 (slot 0) with red light
    preload(0, 260);
    step(8'h01, 8'h00, 8'h00, 1'b1);
    step(8'h00, 8'h00, 8'h00, 1'b1);
    idle(2);

    // s1 (slot 5) arrival coinciding with departures
    preload(5, 5);
    for (int i = 0; i < 8; i++)
      step((i == 3 || i == 7) ? 8'h20 : 8'h00, 8'h00, 8'h01, 1'b0);
    idle(2);

    // emergency arbitration e1 (slot 3) over e2 (slot 2)
    step(8'h0C, 8'h00, 8'h00, 1'b0);
    step(8'h08, 8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h0C, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++)
      step(8'h00, (cnt[3] == 0) ? 8'h04 : 8'h0C, (cnt[3] == 0) ? 8'h00 : 8'h04, 1'b0);
    for (int i = 0; i < 8; i++) step(8'h00, 8'h04, 8'h08, 1'b0);
    idle(6);

    // timeout: e1 held red with an emergency pending
    preload(3, 10);
    for (int i = 0; i < 140; i++) step(8'h00, 8'h08, 8'h00, 1'b0);

    // asynchronous reset mid-run, checked before any clock edge
    @(negedge clk);
    arrive = 8'h00;
    emgReq = 8'h00;
    tlo = 8'h00;
    clrOvf = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    rl = 8'h00;
    rr = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      if (i % 16 == 0) rl = 8'($urandom);
      if ($urandom_range(0, 19) == 0) rr = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      step(8'($urandom) & 8'($urandom), rr, rl, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
